// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg
//   Shared definitions for the segmented-carry add/sub pipeline.
//   uint_fp_t       : native operand type; its width is the default WIDTH.
//   ADDSUB_NSEG_DEF : default number of carry segments.
//   ADDSUB_LAT()    : pipeline latency for a given segment count. Consumers
//                     use it to align side paths with the adder output.
package pipelined_addsub_pkg;

  typedef logic [271:0] uint_fp_t;

  localparam int ADDSUB_NSEG_DEF = 4;

  // One stage of independent segment sums, then one stage per merge level.
  function automatic int ADDSUB_LAT(input int nseg);
    return $clog2(nseg) + 1;
  endfunction

endpackage

// File: rtl/addsub_merge.sv
// addsub_merge
//   Combinational merge of two adjacent partial sums into one partial sum
//   of twice the width. Each input is {carry, W-bit sum}.
//   i_lo  [W:0]    : lower partial sum (its carry ripples upward)
//   i_hi  [W:0]    : upper partial sum
//   o_sum [2*W:0]  : merged partial sum {carry, 2W-bit sum}
module addsub_merge
  import pipelined_addsub_pkg::*;
#(
  parameter int W = 68
) (
  input  logic [W:0]   i_lo,
  input  logic [W:0]   i_hi,
  output logic [2*W:0] o_sum
);

  // The upper partial sum cannot exceed 2^(W+1)-2 (two W-bit operands plus
  // no carry-in), so adding the lower carry never overflows W+1 bits. Its
  // top bit is therefore the merged carry with no extra OR term.
  logic [W:0] w_hi_inc;

  assign w_hi_inc = i_hi + {{W{1'b0}}, i_lo[W]};
  assign o_sum    = {w_hi_inc, i_lo[W-1:0]};

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Wide unsigned adder/subtractor with the carry chain broken into NSEG
//   segments. Stage 0 registers NSEG independent segment sums; each of the
//   log2(NSEG) following stages merges adjacent pairs, so the last stage
//   holds one WIDTH+1-bit value {carry, z}. All stages advance together
//   under a single enable (no per-stage skid).
//
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready = pipeline enable)
//   in_sub              : 0 -> X+Y, 1 -> X-Y
//   in_x, in_y          : WIDTH-bit unsigned operands
//   in_tag              : opaque sideband returned with the result
//   out_valid/out_ready : output handshake
//   out_z               : result modulo 2^WIDTH
//   out_carry           : add: carry out; sub: 1 when X >= Y (no borrow)
//   out_tag             : tag of the result on out_z
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = $bits(uint_fp_t),
  parameter int NSEG  = ADDSUB_NSEG_DEF,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG_W  = WIDTH / NSEG;
  localparam int LOG    = $clog2(NSEG);
  localparam int STAGES = ADDSUB_LAT(NSEG);

  // Reject segment counts the pair-merge tree cannot handle.
  if (!((NSEG == 1) || (NSEG == 2) || (NSEG == 4) || (NSEG == 8)) ||
      ((WIDTH % NSEG) != 0)) begin : g_bad_cfg
    $error("pipelined_addsub: NSEG must be 1/2/4/8 and divide WIDTH");
  end

  // ---------------------------------------------------------------------
  // Flow control: one shared enable, the last stage is the output register.
  // ---------------------------------------------------------------------
  logic w_en;
  logic w_acc;

  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en & ~rst;
  assign w_acc    = in_valid & in_ready;

  // Valid, op and tag shift registers, index k = stage k.
  logic [STAGES-1:0]            r_vld_pipe;
  logic [STAGES-1:0]            r_sub_pipe;
  logic [STAGES-1:0][TAG_W-1:0] r_tag_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_sub_pipe <= '0;
      r_tag_pipe <= '0;
    end else if (w_en) begin
      // A cycle with enable but no acceptance inserts a bubble.
      r_vld_pipe[0] <= w_acc;
      r_sub_pipe[0] <= in_sub;
      r_tag_pipe[0] <= in_tag;
      for (int k = 1; k < STAGES; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_sub_pipe[k] <= r_sub_pipe[k-1];
        r_tag_pipe[k] <= r_tag_pipe[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath. Stage k holds NSEG>>k partial sums of SEG_W<<k bits, each
  // with its own carry bit on top.
  // ---------------------------------------------------------------------
  // Subtraction is X + ~Y + 1; the +1 enters segment 0 only, the other
  // segments receive it through the merge tree.
  logic [WIDTH-1:0] w_y_op;

  assign w_y_op = in_sub ? ~in_y : in_y;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int NS = NSEG >> k;
    localparam int SW = SEG_W << k;

    logic [NS-1:0][SW:0] w_nxt;
    logic [NS-1:0][SW:0] r_seg;

    if (k == 0) begin : g_seg_sum
      for (genvar i = 0; i < NS; i++) begin : g_seg
        logic w_cin;
        assign w_cin    = (i == 0) ? in_sub : 1'b0;
        assign w_nxt[i] = {1'b0, in_x[i*SEG_W +: SEG_W]}
                        + {1'b0, w_y_op[i*SEG_W +: SEG_W]}
                        + {{SEG_W{1'b0}}, w_cin};
      end
    end else begin : g_seg_merge
      for (genvar p = 0; p < NS; p++) begin : g_pair
        addsub_merge #(
          .W (SW / 2)
        ) u_merge (
          .i_lo  (g_stg[k-1].r_seg[2*p]),
          .i_hi  (g_stg[k-1].r_seg[2*p+1]),
          .o_sum (w_nxt[p])
        );
      end
    end

    // Data registers clear on reset so the output bus reads 0 afterwards.
    always_ff @(posedge clk) begin
      if (rst)       r_seg <= '0;
      else if (w_en) r_seg <= w_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs straight from the last stage.
  // ---------------------------------------------------------------------
  // The op bit rides along for debug visibility; the no-borrow carry of
  // X + ~Y + 1 already gives the subtract carry, so nothing consumes it.
  logic w_unused_sub;

  assign w_unused_sub = r_sub_pipe[STAGES-1];

  assign out_valid = r_vld_pipe[STAGES-1];
  assign out_tag   = r_tag_pipe[STAGES-1];
  assign out_z     = g_stg[STAGES-1].r_seg[0][WIDTH-1:0];
  assign out_carry = g_stg[STAGES-1].r_seg[0][WIDTH];

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  localparam int W  = 272;
  localparam int TW = 8;
  localparam int CW = W + TW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, aux_valid, in_sub, out_ready;
  logic [W-1:0]  in_x, in_y;
  logic [TW-1:0] in_tag;

  logic          in_ready, out_valid, out_carry;
  logic [W-1:0]  out_z;
  logic [TW-1:0] out_tag;

  logic          in_ready_1, out_valid_1, out_carry_1;
  logic [W-1:0]  out_z_1;
  logic [TW-1:0] out_tag_1;

  logic          in_ready_8, out_valid_8, out_carry_8;
  logic [W-1:0]  out_z_8;
  logic [TW-1:0] out_tag_8;

  pipelined_addsub #(.WIDTH(W), .NSEG(4), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_carry(out_carry), .out_tag(out_tag));

  pipelined_addsub #(.WIDTH(W), .NSEG(1), .TAG_W(TW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(aux_valid), .in_ready(in_ready_1),
    .in_sub(in_sub), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid_1), .out_ready(1'b1), .out_z(out_z_1),
    .out_carry(out_carry_1), .out_tag(out_tag_1));

  pipelined_addsub #(.WIDTH(W), .NSEG(8), .TAG_W(TW)) dut8 (
    .clk(clk), .rst(rst), .in_valid(aux_valid), .in_ready(in_ready_8),
    .in_sub(in_sub), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid_8), .out_ready(1'b1), .out_z(out_z_8),
    .out_carry(out_carry_8), .out_tag(out_tag_8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, result as {carry, z}.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] r;
    if (!s) r = {1'b0, x} + {1'b0, y};
    else    r = {(x >= y), x - y};
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // Push one op into all three pipelines and check each emits it exactly
  // at its own latency (NSEG=1 ->1, 4 ->3, 8 ->4) and then drops valid.
  task automatic corner(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [TW-1:0] t);
    logic [W:0] e;
    e = model(x, y, s);
    @(negedge clk);
    in_valid = 1'b1; aux_valid = 1'b1; out_ready = 1'b1;
    in_x = x; in_y = y; in_sub = s; in_tag = t;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0; aux_valid = 1'b0;
      #1;
      chk({nm, "/vld4"}, CW'(out_valid),   CW'(k == 3));
      chk({nm, "/vld1"}, CW'(out_valid_1), CW'(k == 1));
      chk({nm, "/vld8"}, CW'(out_valid_8), CW'(k == 4));
      if (k == 3) begin
        chk({nm, "/res4"}, CW'({out_carry, out_z}), CW'(e));
        chk({nm, "/tag4"}, CW'(out_tag), CW'(t));
      end
      if (k == 1) begin
        chk({nm, "/res1"}, CW'({out_carry_1, out_z_1}), CW'(e));
        chk({nm, "/tag1"}, CW'(out_tag_1), CW'(t));
      end
      if (k == 4) begin
        chk({nm, "/res8"}, CW'({out_carry_8, out_z_8}), CW'(e));
        chk({nm, "/tag8"}, CW'(out_tag_8), CW'(t));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]    all1, one, v;
    logic [CW-1:0]   exp_q[$];
    logic [CW-1:0]   e, saved;
    logic            held, pend;
    int              n_sent, n_out;

    all1 = '1;
    one  = W'(1);
    rst = 1'b1; in_valid = 1'b0; aux_valid = 1'b0; in_sub = 1'b0;
    in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b1;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    #1;
    chk("rst/out_valid", CW'(out_valid), '0);
    chk("rst/out_z",     CW'(out_z), '0);
    chk("rst/out_carry", CW'(out_carry), '0);
    chk("rst/out_tag",   CW'(out_tag), '0);
    chk("rst/in_ready",  CW'(in_ready), '0);
    chk("rst/vld1",      CW'(out_valid_1), '0);
    chk("rst/vld8",      CW'(out_valid_8), '0);
    @(negedge clk);
    rst = 1'b0;

    // ---- directed boundaries, all three segment counts ----
    corner("add_wrap", all1, one, 1'b0, 8'h11);
    corner("sub_neg", W'(5), W'(7), 1'b1, 8'h22);
    corner("sub_eq", W'(16'h1234), W'(16'h1234), 1'b1, 8'h33);
    v = (one << 68) - one;
    corner("seg68", v, one, 1'b0, 8'h44);
    v = (one << 204) - one;
    corner("seg204", v, one, 1'b0, 8'h55);
    v = (one << 34) - one;
    corner("seg34", v, one, 1'b0, 8'h66);
    for (int i = 0; i < 4; i++)
      corner("rand", rnd(), rnd(), 1'($urandom()), 8'($urandom()));

    // ---- stream of 10 with a 4-cycle output stall ----
    n_sent = 0; n_out = 0; held = 1'b0; pend = 1'b0; saved = '0;
    for (int c = 0; c < 80 && n_out < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 8);
      #1;
      if (held) begin
        chk("stall/hold_vld", CW'(out_valid), CW'(1));
        chk("stall/hold_data", CW'({out_tag, out_carry, out_z}), saved);
      end
      chk("stream/in_ready", CW'(in_ready), CW'(!out_valid || out_ready));
      if (c >= 5 && c <= 8) chk("stall/in_ready", CW'(in_ready), '0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("stream/extra_out", CW'(out_tag), '1);
        else begin
          e = exp_q.pop_front();
          chk("stream/result", CW'({out_tag, out_carry, out_z}), e);
        end
        n_out++;
      end
      held  = out_valid && !out_ready;
      saved = {out_tag, out_carry, out_z};
      if (n_sent < 10) begin
        if (!pend) begin
          in_x = rnd(); in_y = rnd(); in_sub = 1'($urandom());
          if ($urandom_range(0, 3) == 0) in_y = in_x;
          in_tag = TW'(n_sent);
          pend = 1'b1;
        end
        in_valid = 1'b1;
        if (in_ready) begin
          exp_q.push_back({in_tag, model(in_x, in_y, in_sub)});
          n_sent++;
          pend = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream/count", CW'(n_out), CW'(10));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;

    // ---- reset discards in-flight ops ----
    @(negedge clk);
    in_x = rnd(); in_y = rnd(); in_sub = 1'b0; in_tag = 8'hA0; in_valid = 1'b1;
    #1 chk("rstf/acc1", CW'(in_ready), CW'(1));
    @(negedge clk);
    in_x = rnd(); in_y = rnd(); in_sub = 1'b1; in_tag = 8'hA1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rstf/in_ready", CW'(in_ready), '0);
    chk("rstf/vld_pre", CW'(out_valid), '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstf/out_valid", CW'(out_valid), '0);
    chk("rstf/out_zct", CW'({out_tag, out_carry, out_z}), '0);
    in_x = rnd(); in_y = rnd(); in_sub = 1'b1; in_tag = 8'hA2; in_valid = 1'b1;
    e = {in_tag, model(in_x, in_y, in_sub)};
    #1 chk("rstf/first_ready", CW'(in_ready), CW'(1));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("rstf/vld", CW'(out_valid), CW'(k == 3));
      if (k == 3) chk("rstf/result", CW'({out_tag, out_carry, out_z}), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 272: operand and result width in bits; matches $bits(uint_fp_t).
REQ-002 Parameter NSEG, default 4: number of carry segments; legal values 1, 2, 4, 8.
REQ-003 Parameter TAG_W, default 8: width of the sideband tag carried alongside each operation.
REQ-004 Port clk  in  1: single clock; all state updates on posedge clk.
REQ-005 Port rst  in  1: reset, synchronous, active-high.
REQ-006 Port in_valid  in  1: input transaction present.
REQ-007 Port in_ready  out  1: block accepts the input transaction this cycle.
REQ-008 Port in_sub  in  1: 0 selects Z = X + Y; 1 selects Z = X - Y.
REQ-009 Port in_x, in_y  in  WIDTH each: unsigned operands.
REQ-010 Port in_tag  in  TAG_W: opaque tag, returned unchanged with the result.
REQ-011 Port out_valid  out  1: result present.
REQ-012 Port out_ready  in  1: downstream consumes the result this cycle.
REQ-013 Port out_z  out  WIDTH: result modulo 2^WIDTH.
REQ-014 Port out_carry  out  1: add: bit WIDTH of X+Y; sub: 1 iff X >= Y (no borrow).
REQ-015 Port out_tag  out  TAG_W: tag of the transaction on out_z.

Function
REQ-016 Elaboration SHALL fail if NSEG is not in {1,2,4,8} or WIDTH mod NSEG != 0; SEG_W = WIDTH/NSEG.
REQ-017 Latency SHALL be L = log2(NSEG)+1 cycles from acceptance to out_valid, absent stalls; NSEG=1 gives L=1.
REQ-018 Stage 1 SHALL register NSEG independent (SEG_W+1)-bit segment sums, with Y inverted when sub=1 and +1 injected into segment 0 only.
REQ-019 Each later stage SHALL merge adjacent segment pairs: the upper partial sum is incremented by the carry of the lower one, and the lower bits pass unchanged.
REQ-020 The final stage SHALL produce {out_carry, out_z} from a single merged WIDTH+1-bit value.
REQ-021 The in_sub and in_tag values SHALL travel with their data through every stage.
REQ-022 Pipeline advance: enable = ~out_valid | out_ready. All stages shift together when enable=1 and hold when enable=0.
REQ-023 in_ready SHALL equal enable and SHALL be 0 while rst=1. A transaction is accepted iff in_valid & in_ready.
REQ-024 Each stage SHALL carry a valid bit. A bubble (enable=1 with no acceptance) SHALL propagate as valid=0.
REQ-025 While out_valid=1 and out_ready=0, out_z, out_carry and out_tag SHALL hold stable.
REQ-026 Throughput SHALL be one transaction per cycle when out_ready=1 continuously; results leave in acceptance order.
REQ-027 Simultaneous output consume and input accept in the same cycle SHALL lose no transaction.

Reset
REQ-028 On a clock edge with rst=1, all stage valid bits SHALL clear and out_valid, out_z, out_carry and out_tag SHALL become 0.
REQ-029 Transactions in flight when rst asserts SHALL be discarded and never appear on the output.
REQ-030 The first input after reset SHALL be accepted in the cycle after rst deasserts, if in_valid=1.

Structure
REQ-031 The shared params package SHALL hold a default NSEG constant and a latency function, ADDSUB_LAT(nseg) = clog2(nseg)+1, used by consumers for alignment.
REQ-032 A sub-module, addsub_merge, SHALL implement one combinational pair-merge (lower/upper partial sums in, merged sum out). The top SHALL instantiate it per pair per stage via generate.
REQ-033 No vendor primitives; carry chains SHALL be inferred.

Verification (WIDTH=272, NSEG=4, L=3)
REQ-034 Add X=2^272-1, Y=1, out_ready=1 -> after 3 cycles out_z=0, out_carry=1, tag echoed.
REQ-035 Sub X=5, Y=7 -> out_z=2^272-2, out_carry=0; sub X=Y=0x1234 -> out_z=0, out_carry=1.
REQ-036 Add X=2^68-1, Y=1 (segment boundary) and X=2^204-1, Y=1 -> out_z=2^68 and out_z=2^204, out_carry=0.
REQ-037 Stream 10 back-to-back random add/sub ops with tags 0..9, out_ready low for cycles 5-8 -> all 10 results correct, in order, in_ready low while stalled, outputs held stable.
REQ-038 Accept 2 ops, assert rst for 1 cycle at cycle 2 -> out_valid stays 0, nothing emitted; the next op after reset returns after 3 cycles.
REQ-039 Rerun REQ-034 to REQ-036 with NSEG=1 and NSEG=8 -> identical results with latencies 1 and 4.
